// File: rtl/lc3_int_ctrl.sv
// LC-3 interrupt controller: edge-latched sources, priority arbitration,
// and a req/ack handshake that offers one vector at a time to the CPU.
module lc3_int_ctrl #(
   parameter int         N_SRC    = 8,
   parameter logic [7:0] VEC_BASE = 8'h80
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_SRC-1:0]   irq,
   input  logic [N_SRC-1:0]   irq_en,
   input  logic [3*N_SRC-1:0] src_pri,
   input  logic [2:0]         cur_pri,
   input  logic               int_ack,
   output logic               int_req,
   output logic [7:0]         int_vec,
   output logic [2:0]         int_pri,
   output logic [N_SRC-1:0]   pending
);

   localparam int IW = 4;

   typedef enum logic [1:0] {
      IDLE,
      ARB,
      REQ,
      DONE
   } state_t;

   state_t           state;
   logic [N_SRC-1:0] irq_q;
   logic [N_SRC-1:0] irq_rise;
   logic [N_SRC-1:0] elig;
   logic [N_SRC-1:0] clr_mask;
   logic [IW-1:0]    win_idx;
   logic [IW-1:0]    best_idx;
   logic [2:0]       best_pri;
   logic             best_found;
   logic             win_elig;
   logic             ack_take;

   assign irq_rise = irq & ~irq_q;
   assign ack_take = (state == REQ) && int_ack;

   // Which sources may be offered right now
   always_comb begin
      elig = '0;
      for (int i = 0; i < N_SRC; i++) begin
         elig[i] = pending[i] & irq_en[i]
                 & (src_pri[3*i +: 3] > cur_pri);
      end
   end

   // Highest level wins; scanning upward with >= hands ties to the higher index
   always_comb begin
      best_found = 1'b0;
      best_pri   = '0;
      best_idx   = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (elig[i] && (!best_found || src_pri[3*i +: 3] >= best_pri)) begin
            best_found = 1'b1;
            best_pri   = src_pri[3*i +: 3];
            best_idx   = IW'(i);
         end
      end
   end

   // Eligibility of the latched winner and its clear mask on ack
   always_comb begin
      win_elig = 1'b0;
      clr_mask = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (win_idx == IW'(i)) begin
            win_elig    = elig[i];
            clr_mask[i] = ack_take;
         end
      end
   end

   // Edge history and pending latch; a new edge beats a same-cycle clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_q   <= '1;
         pending <= '0;
      end else begin
         irq_q   <= irq;
         pending <= (pending & ~clr_mask) | irq_rise;
      end
   end

   // Offer sequencing with registered handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         int_req <= 1'b0;
         int_vec <= '0;
         int_pri <= '0;
         win_idx <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (|elig) begin
                  state <= ARB;
               end
            end
            ARB: begin
               if (best_found) begin
                  win_idx <= best_idx;
                  int_vec <= VEC_BASE + {4'b0000, best_idx};
                  int_pri <= best_pri;
                  int_req <= 1'b1;
                  state   <= REQ;
               end else begin
                  state <= IDLE;
               end
            end
            REQ: begin
               if (int_ack) begin
                  int_req <= 1'b0;
                  state   <= DONE;
               end else if (!win_elig) begin
                  int_req <= 1'b0;
                  state   <= IDLE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               int_req <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule
